uart_rx: RTL and testbench

// - 8-bit UART receiver, 8N1 (8E1 with parity option); LSB first, line idles high.
// - Consumes the serial line driven by uart_tx.
// - Synchronises rx, validates start bit at mid-bit, samples each bit at mid-bit.
// - Presents each byte with a one-cycle valid strobe.

---
 rtl/uart_rx_pkg.sv | 21 ++
 rtl/uart_rx_sync.sv | 31 +++
 rtl/uart_rx.sv | 146 ++++++++++++++
 tb/tb_uart_rx.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared UART receive definitions: data width, FSM states, parity helper
`timescale 1ns/1ps
package uart_rx_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    WAIT_HI = 3'd5
  } uart_state_e;

  // Even parity: the parity bit that makes the total count of ones even.
  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// rtl/uart_rx_sync.sv - 2-flop synchroniser for the rx line plus a one-cycle delayed copy for edge detect
`timescale 1ns/1ps
module uart_rx_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic rx_i,
  output logic rx_s_o,
  output logic rx_prev_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Reset to the idle-high line level so reset release never looks like a falling edge.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= rx_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rx_s_o    = sync_q;
  assign rx_prev_o = prev_q;

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with mid-bit sampling and one-cycle result strobes
// Define UART_RX_PARITY_EN for 8E1 frames (even parity bit between D7 and stop).
`timescale 1ns/1ps
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx,
  output logic [UART_DATA_BITS-1:0] data_out,
  output logic                      valid,
  output logic                      busy,
  output logic                      frame_err,
  output logic                      parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      rx_s;
  logic                      rx_prev;
  logic                      start_edge;
  uart_state_e               state_q;
  logic [CNT_W-1:0]          cnt_q;
  logic [2:0]                bit_idx_q;
  logic [UART_DATA_BITS-1:0] shreg_q;
  logic [UART_DATA_BITS-1:0] data_q;
  logic                      valid_q;
  logic                      frame_err_q;
`ifdef UART_RX_PARITY_EN
  logic                      parity_ok_q;
  logic                      parity_err_q;
`endif

  uart_rx_sync u_sync (
    .clk_i     (clk),
    .rst_ni    (rst),
    .rx_i      (rx),
    .rx_s_o    (rx_s),
    .rx_prev_o (rx_prev)
  );

  assign start_edge = rx_prev & ~rx_s;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_ok_q  <= 1'b1;
      parity_err_q <= 1'b0;
`endif
    end else begin
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err_q <= 1'b0;
`endif
      cnt_q <= cnt_q + CNT_W'(1);
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (start_edge) state_q <= START;
        end
        START: begin
          // A start bit that is high again at mid-bit was a glitch.
          if (cnt_q == HALF_M1) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s ? IDLE : DATA;
          end
        end
        DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q     <= '0;
            shreg_q   <= {rx_s, shreg_q[UART_DATA_BITS-1:1]};
            bit_idx_q <= bit_idx_q + 3'd1;
            if (bit_idx_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state_q <= PARITY;
`else
              state_q <= STOP;
`endif
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt_q == FULL_M1) begin
            cnt_q       <= '0;
            parity_ok_q <= (rx_s == even_parity(shreg_q));
            state_q     <= STOP;
          end
        end
`endif
        STOP: begin
          // Framing error wins over parity so at most one strobe fires per frame.
          if (cnt_q == FULL_M1) begin
            cnt_q <= '0;
            if (!rx_s) begin
              frame_err_q <= 1'b1;
              state_q     <= WAIT_HI;
`ifdef UART_RX_PARITY_EN
            end else if (!parity_ok_q) begin
              parity_err_q <= 1'b1;
              state_q      <= IDLE;
`endif
            end else begin
              data_q  <= shreg_q;
              valid_q <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        WAIT_HI: begin
          cnt_q <= '0;
          if (rx_s) state_q <= IDLE;
        end
        default: begin
          cnt_q   <= '0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign data_out  = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign busy      = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx at CLKS_PER_BIT=4, 5 ns clock
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int C = 4;
`ifdef UART_RX_PARITY_EN
  localparam int NBITS = 10;
`else
  localparam int NBITS = 9;
`endif
  // Edge E is one edge after the drive point; valid follows 2 + C/2 + NBITS*C edges later.
  localparam int LAT = 1 + 2 + C / 2 + NBITS * C;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx  = 1'b1;
  logic [7:0] data_out;
  logic       valid;
  logic       busy;
  logic       frame_err;
  logic       parity_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int excl_viol = 0;
  int valid_cyc = 0;
  int t_start = 0;
  logic [7:0] vlog [64];

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .data_out   (data_out),
    .valid      (valid),
    .busy       (busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  always #2.5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (valid) begin
      vlog[valid_cnt % 64] = data_out;
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
    end
    if (frame_err) ferr_cnt = ferr_cnt + 1;
    if (parity_err) perr_cnt = perr_cnt + 1;
    if (int'(valid) + int'(frame_err) + int'(parity_err) > 1) excl_viol = excl_viol + 1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (C) @(posedge clk);
    #1;
  endtask

  task automatic send_raw(input logic [7:0] d, input logic pbit, input logic stop_bit);
    t_start = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(pbit);
`else
    if (pbit === 1'bx) rx = 1'b1;
`endif
    drive_bit(stop_bit);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    send_raw(d, ^d, stop_bit);
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int v0;
    int f0;
    int p0;
    logic saw_hi;
    logic fell;

    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_data", 32'(data_out), 32'h00);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_frame_err", 32'(frame_err), 0);
    chk("rst_parity_err", 32'(parity_err), 0);
    rst = 1'b1;
    idle(4);

    // Single frame, as uart_tx would send 8'h03.
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'h03, 1'b1);
    idle(3 * C);
    chk("lb_valid_count", 32'(valid_cnt - v0), 1);
    chk("lb_data", 32'(vlog[v0 % 64]), 32'h03);
    chk("lb_data_out", 32'(data_out), 32'h03);
    chk("lb_frame_err", 32'(ferr_cnt - f0), 0);
    chk("lb_latency", 32'(valid_cyc - t_start), 32'(LAT));
    chk("lb_busy", 32'(busy), 0);

    // Back-to-back frames with no idle gap.
    v0 = valid_cnt;
    send_frame(8'hA5, 1'b1);
    send_frame(8'h5A, 1'b1);
    idle(3 * C);
    chk("b2b_valid_count", 32'(valid_cnt - v0), 2);
    chk("b2b_first", 32'(vlog[v0 % 64]), 32'hA5);
    chk("b2b_second", 32'(vlog[(v0 + 1) % 64]), 32'h5A);

    // One-clock glitch low.
    v0 = valid_cnt; f0 = ferr_cnt;
    saw_hi = 1'b0; fell = 1'b0;
    rx = 1'b0;
    @(posedge clk);
    #1;
    rx = 1'b1;
    for (int k = 0; k < C / 2 + 3; k++) begin
      @(posedge clk);
      #1;
      if (busy) saw_hi = 1'b1;
      if (saw_hi && !busy) fell = 1'b1;
    end
    idle(2 * C);
    chk("glitch_busy_rose", 32'(saw_hi), 1);
    chk("glitch_busy_fell", 32'(fell), 1);
    chk("glitch_valid", 32'(valid_cnt - v0), 0);
    chk("glitch_frame_err", 32'(ferr_cnt - f0), 0);

    // Bad stop bit followed by a break.
    v0 = valid_cnt; f0 = ferr_cnt;
    send_frame(8'hFF, 1'b0);
    rx = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("brk_busy_high", 32'(busy), 1);
    chk("brk_frame_err", 32'(ferr_cnt - f0), 1);
    chk("brk_valid", 32'(valid_cnt - v0), 0);
    chk("brk_data_hold", 32'(data_out), 32'h5A);
    idle(6);
    chk("brk_busy_low", 32'(busy), 0);
    v0 = valid_cnt;
    send_frame(8'h3C, 1'b1);
    idle(3 * C);
    chk("brk_next_valid", 32'(valid_cnt - v0), 1);
    chk("brk_next_data", 32'(data_out), 32'h3C);

    // Reset pulse while in DATA.
    v0 = valid_cnt;
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_data", 32'(data_out), 32'h00);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(valid), 0);
    rst = 1'b1;
    idle(4 * C);
    chk("mid_rst_no_valid", 32'(valid_cnt - v0), 0);
    send_frame(8'h81, 1'b1);
    idle(3 * C);
    chk("mid_rst_next_valid", 32'(valid_cnt - v0), 1);
    chk("mid_rst_next_data", 32'(data_out), 32'h81);

`ifdef UART_RX_PARITY_EN
    v0 = valid_cnt; p0 = perr_cnt;
    send_raw(8'h07, 1'b0, 1'b1);
    idle(3 * C);
    chk("par_bad_perr", 32'(perr_cnt - p0), 1);
    chk("par_bad_valid", 32'(valid_cnt - v0), 0);
    chk("par_bad_hold", 32'(data_out), 32'h81);
    send_raw(8'h07, 1'b1, 1'b1);
    idle(3 * C);
    chk("par_good_valid", 32'(valid_cnt - v0), 1);
    chk("par_good_data", 32'(data_out), 32'h07);
    chk("par_good_perr", 32'(perr_cnt - p0), 1);
`else
    p0 = 0;
    chk("no_parity_err", 32'(perr_cnt - p0), 0);
`endif
    chk("strobe_exclusive", 32'(excl_viol), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
